// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter and the SRAM leg of bridge_1x3.
package ram_port_arbiter_pkg;

  localparam int RAM_AW  = 16;
  localparam int DATA_WD = 64;
  localparam int STRB_WD = DATA_WD / 8;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the requester not granted last wins a conflict.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_gnt;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == REQ_LDR) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to the loader so the CPU wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst)         last_gnt <= REQ_LDR;
    else if (gnt[0]) last_gnt <= REQ_CPU;
    else if (gnt[1]) last_gnt <= REQ_LDR;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port a between the CPU SRAM leg (m0) and the loader/debug port (m1),
// and steers the 1-cycle read response back to the requester that issued it.
module ram_port_arbiter #(
  parameter int RAM_AW  = ram_port_arbiter_pkg::RAM_AW,
  parameter int DATA_WD = ram_port_arbiter_pkg::DATA_WD,
  parameter int STRB_WD = ram_port_arbiter_pkg::STRB_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic [STRB_WD-1:0] m0_we,
  input  logic [63:0]        m0_addr,
  input  logic [DATA_WD-1:0] m0_wdata,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  output logic [DATA_WD-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic [STRB_WD-1:0] m1_we,
  input  logic [63:0]        m1_addr,
  input  logic [DATA_WD-1:0] m1_wdata,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [DATA_WD-1:0] m1_rdata,
  output logic               ram_en,
  output logic [STRB_WD-1:0] ram_we,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [DATA_WD-1:0] ram_wdata,
  input  logic [DATA_WD-1:0] ram_rdata
);
  import ram_port_arbiter_pkg::*;

  typedef struct packed {
    logic [STRB_WD-1:0] we;
    logic [63:0]        addr;
    logic [DATA_WD-1:0] wdata;
  } port_req_t;

  logic [1:0]  gnt;
  port_req_t   sel;
  resp_state_t state, state_nxt;
  req_id_t     owner, owner_nxt;
  logic        resp_live;
  logic        unused_addr_bits;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Idle port drives zeros so ram_we is 0 whenever nothing is granted.
  always_comb begin
    sel = '0;
    if (gnt[0])      sel = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    else if (gnt[1]) sel = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
  end

  assign ram_en    = |gnt;
  assign ram_we    = sel.we;
  assign ram_addr  = sel.addr[RAM_AW+2:3];
  assign ram_wdata = sel.wdata;

  // Byte offset and bits above the RAM span are intentionally dropped.
  assign unused_addr_bits = ^{sel.addr[63:RAM_AW+3], sel.addr[2:0]};

  always_comb begin
    state_nxt = ST_IDLE;
    owner_nxt = owner;
    if (ram_en && (ram_we == '0)) begin
      state_nxt = ST_RESP;
      owner_nxt = gnt[1] ? REQ_LDR : REQ_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= REQ_CPU;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // A response still pending when reset arrives is suppressed immediately.
  assign resp_live = (state == ST_RESP) && !rst;
  assign m0_rvalid = resp_live && (owner == REQ_CPU);
  assign m1_rvalid = resp_live && (owner == REQ_LDR);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of dual_port_ram_64 between two requesters.
  - m0: the CPU data path, i.e. the bridge_1x3 SRAM leg.
  - m1: the program loader / debug requester.
- Round-robin arbitration with a fixed 1-cycle grant-to-read-data latency.
- Routes the read response back to the requester that issued the read.
- Sits between the bridge/loader and RAM port a, inside mycpu_top.

Parameters:
- RAM_AW, 16, RAM word-address width (64-bit words).
- DATA_WD, 64, data width.
- STRB_WD, 8, byte-enable width (DATA_WD/8).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- m0_req  input  1  CPU request valid; held stable until m0_gnt
- m0_we  input  STRB_WD  byte write enables; all zero = read
- m0_addr  input  64  byte address
- m0_wdata  input  DATA_WD  write data
- m0_gnt  output  1  request accepted this cycle
- m0_rvalid  output  1  read data valid
- m0_rdata  output  DATA_WD  read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the loader/debug requester
- ram_en  output  1  RAM port enable
- ram_we  output  STRB_WD  RAM byte write enables
- ram_addr  output  RAM_AW  RAM word address
- ram_wdata  output  DATA_WD  RAM write data
- ram_rdata  input  DATA_WD  RAM read data, valid 1 cycle after ram_en with ram_we==0

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high, sampled on the clk rising edge.
- Reset values: last_gnt=1 (so m0 wins the first conflict), resp_pend=0, resp_owner=0.
  - m0_rvalid=m1_rvalid=0; gnt outputs follow req and are therefore 0 when no request is present.
- Grant is combinational, in the same cycle as req.
  - Only one req asserted: that requester is granted.
  - Both asserted: the requester that is not last_gnt is granted.
  - last_gnt updates on every grant.
- Exactly one grant per cycle at most; throughput is 1 access/cycle with no bubbles.
- A requester that loses a conflict is granted in the next cycle; worst-case wait is 1 cycle.
- RAM drive:
  - ram_en = m0_gnt | m1_gnt.
  - ram_we, ram_wdata come from the granted requester.
  - ram_addr = granted addr[RAM_AW+2:3].
  - addr[2:0] is ignored; byte lanes are selected by we.
  - Upper address bits are ignored, so addresses wrap modulo 2^(RAM_AW+3) bytes.
  - With no grant, ram_we=0; ram_addr and ram_wdata are don't-care but are held at 0.
- Response FSM with states IDLE and RESP:
  - A granted read (we==0) sets resp_pend=1 and resp_owner=granted id.
  - In the next cycle, mX_rvalid=1 for the owner only, and mX_rdata=ram_rdata.
  - A granted write produces no rvalid.
  - A new grant in the RESP cycle is legal (pipelined); resp_pend reloads from that grant or clears if there is none.
- Non-owner rdata is driven 0, so the non-owner always sees rvalid=0 and rdata=0.
- Read-after-write to the same word in consecutive cycles returns the written data, by RAM write-first ordering.
  - If the two accesses come from different requesters, their order is the grant order.
- Reset asserted while resp_pend=1: the pending response is dropped; rvalid=0 in the cycle after reset.
- Requester contract: a requester changing addr/we/wdata while req=1 and gnt=0 is a protocol violation.
  - The bench asserts this contract is never violated; the RTL need not handle it.

Decomposition:
- Shared package: the requester-id type (0=CPU, 1=loader), RAM_AW, and DATA_WD/STRB_WD constants, shared with bridge_1x3.
- One natural sub-module: rr_arb2, a two-way round-robin picker holding last_gnt, with inputs req[1:0] and output gnt[1:0].
- The response FSM and muxing stay in ram_port_arbiter.

Test Plan:
- After reset: m0 writes we=0xFF, addr=0x40, wdata=0x1122334455667788, then reads 0x40.
  - Required: m0_gnt in the same cycle as each req, ram_addr=0x8, m0_rvalid one cycle after the read grant with rdata=0x1122334455667788, m1_rvalid=0 throughout.
- m0 and m1 both read in cycle 0 (m0 addr 0x0, m1 addr 0x8).
  - Required: m0 granted in cycle 0, m1 in cycle 1; m0_rvalid in cycle 1, m1_rvalid in cycle 2, each carrying its own word.
- Both requesters hold req continuously for 8 cycles.
  - Required: grants alternate m0,m1,m0,…; exactly 4 grants each; ram_en=1 every cycle.
- Byte-lane write: m1 writes we=0x0F, addr=0x40, wdata=0xAAAAAAAAAAAAAAAA over prior 0x1122334455667788, then m0 reads 0x40.
  - Required: rdata=0x11223344AAAAAAAA.
- Address wrap: with RAM_AW=16, m0 writes addr=0x80000 + 0x10, then reads 0x10.
  - Required: the read returns the written data.
- Reset mid-flight: a read is granted in cycle N and rst=1 in cycle N+1.
  - Required: no rvalid in cycle N+1 or N+2; the first conflict after reset is won by m0.
